sw_cmd_capture: RTL and testbench

//  Input-side companion to the LED output path of the board top level.

---
 rtl/sw_cmd_capture_pkg.sv | 18 +
 rtl/cmd_fifo.sv | 66 ++++++
 rtl/sw_cmd_capture.sv | 90 +++++++++
 tb/tb_sw_cmd_capture.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_cmd_capture_pkg.sv
// Shared definitions for the switch command capture block.
// Holds the default switch width, debounce lengths and queue depth,
// plus a sizing helper used by the command FIFO.
package sw_cmd_capture_pkg;

    localparam int SW_W_DEF       = 3;
    // Short debounce for simulation; board builds override DEB_CYCLES
    // with DEB_CYCLES_BOARD (about 20 ms at 50 MHz).
    localparam int DEB_CYCLES_SIM   = 4;
    localparam int DEB_CYCLES_BOARD = 1_000_000;
    localparam int FIFO_DEPTH_DEF   = 4;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int occ_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Purpose: synchronous show-ahead FIFO; rd_data is the head entry (0 when empty).
// Latency: a write is visible at rd_data on the edge after wr_en when empty.
// Backpressure: a write while full is dropped unless a read completes on the same edge.
// Ports: clk, rst (async active-low), wr_en/wr_data, rd_en/rd_data, empty, full.
module cmd_fifo
    import sw_cmd_capture_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_bits(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;

    logic do_rd;
    logic do_wr;

    assign empty = (count == '0);
    assign full  = (count == OCC_W'(DEPTH));

    // A read frees the slot on the same edge, so a full FIFO still
    // accepts a write when the head is being consumed.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: it is never observed while count is 0.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sw_cmd_capture.sv
// Purpose: synchronise and debounce slide switches; each settled change is queued as a command.
// Latency: SW change before edge E0 commits (sw_stable, push) at edge E0+DEB_CYCLES+2.
// Backpressure: cmd_valid/cmd_ready; commands arriving at a full queue are dropped and flag overflow.
// Ports: clk, rst (async active-low), SW (raw switches), cmd_data/cmd_valid/cmd_ready
//        (command handshake), sw_stable (debounced value), overflow (sticky drop flag).
module sw_cmd_capture
    import sw_cmd_capture_pkg::*;
#(
    parameter int SW_W       = SW_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_SIM,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] SW,
    output logic [SW_W-1:0] cmd_data,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [SW_W-1:0] sw_stable,
    output logic            overflow
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SW_W-1:0]  sync1;
    logic [SW_W-1:0]  sync2;
    logic [SW_W-1:0]  last;
    logic [SW_W-1:0]  stable;
    logic [CNT_W-1:0] cnt;

    logic push;
    logic pop;
    logic fifo_empty;
    logic fifo_full;

    // Commit when the synchronised value differs from the debounced one,
    // has not moved since last cycle, and has been seen long enough.
    assign push = (sync2 != stable) && (sync2 == last) && (cnt == CNT_LAST);
    assign pop  = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            last     <= '0;
            stable   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
            last  <= sync2;

            if (sync2 == stable) begin
                cnt <= '0;
            end else if (sync2 != last) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A same-edge pop makes room, so only an unconsumed full queue drops.
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    cmd_fifo #(
        .WIDTH (SW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (sync2),
        .rd_en   (cmd_ready),
        .rd_data (cmd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign cmd_valid = !fifo_empty;
    assign sw_stable = stable;

endmodule

// File: tb/tb_sw_cmd_capture.sv
// Directed bench for sw_cmd_capture: reset, glitch rejection, handshake,
// queue fill/overflow, full push+pop, and reset during debounce.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_sw_cmd_capture;

    logic       clk;
    logic       rst;
    logic [2:0] sw;
    logic [2:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] sw_stable;
    logic       overflow;

    int checks;
    int errors;

    sw_cmd_capture #(
        .SW_W       (3),
        .DEB_CYCLES (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (sw),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .sw_stable (sw_stable),
        .overflow  (overflow)
    );

    // Rising edges at 20, 40, 60 ... ns so the 30 ns release sits between edges.
    initial begin
        clk = 1'b1;
        forever #10 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        sw  = 3'd0;
        cmd_ready = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(8);
    endtask

    // SW=5 through reset; after release the first edge is E0 and the
    // command commits at E0+6, i.e. the 7th edge seen after release.
    task automatic test_reset();
        rst = 1'b1;
        sw  = 3'b101;
        cmd_ready = 1'b0;
        #1 rst = 1'b0;
        #24;
        checks++;
        if ({cmd_valid, cmd_data, sw_stable, overflow} !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%0d stable=%0d ovf=%b, want all 0",
                     cmd_valid, cmd_data, sw_stable, overflow);
        end
        #5 rst = 1'b1;              // released at 30 ns
        tick(6);                    // E0..E5
        checks++;
        if (cmd_valid !== 1'b0 || sw_stable !== 3'd0) begin
            errors++;
            $display("FAIL reset_early: got valid=%b stable=%0d at E0+5, want 0/0", cmd_valid, sw_stable);
        end
        tick(1);                    // E6
        checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== 3'd5 || sw_stable !== 3'd5) begin
            errors++;
            $display("FAIL reset_first_cmd: got valid=%b data=%0d stable=%0d, want 1/5/5",
                     cmd_valid, cmd_data, sw_stable);
        end
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pop: got valid=%b, want 0", cmd_valid);
        end
    endtask

    // SW=2 held only 3 cycles then back to 0: never reaches commit.
    task automatic test_glitch();
        apply_reset();
        sw = 3'b010;
        tick(3);
        sw = 3'b000;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            checks++;
            if (cmd_valid !== 1'b0 || sw_stable !== 3'd0) begin
                errors++;
                $display("FAIL glitch_cycle%0d: got valid=%b stable=%0d, want 0/0", i, cmd_valid, sw_stable);
            end
        end
    endtask

    task automatic test_handshake();
        sw = 3'b011;
        cmd_ready = 1'b0;
        tick(8);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== 3'd3) begin
            errors++;
            $display("FAIL hs_valid: got valid=%b data=%0d, want 1/3", cmd_valid, cmd_data);
        end
        tick(3);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== 3'd3) begin
            errors++;
            $display("FAIL hs_hold: got valid=%b data=%0d, want 1/3", cmd_valid, cmd_data);
        end
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_data !== 3'd0) begin
            errors++;
            $display("FAIL hs_pop: got valid=%b data=%0d, want 0/0", cmd_valid, cmd_data);
        end
        // ready while empty must not disturb anything
        cmd_ready = 1'b1;
        tick(2);
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL hs_ready_empty: got valid=%b ovf=%b, want 0/0", cmd_valid, overflow);
        end
    endtask

    task automatic test_fill_overflow();
        logic [2:0] exp_q [4];
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4};
        apply_reset();
        for (int v = 1; v <= 5; v++) begin
            sw = 3'(v);
            tick(8);
        end
        checks++;
        if (overflow !== 1'b1 || sw_stable !== 3'd5 || cmd_data !== 3'd1) begin
            errors++;
            $display("FAIL fill_state: got ovf=%b stable=%0d head=%0d, want 1/5/1",
                     overflow, sw_stable, cmd_data);
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== exp_q[i]) begin
                errors++;
                $display("FAIL fill_drain%0d: got valid=%b data=%0d, want 1/%0d",
                         i, cmd_valid, cmd_data, exp_q[i]);
            end
            tick(1);
        end
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_after: got valid=%b ovf=%b, want 0/1 (sticky)", cmd_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [2:0] exp_q [4];
        exp_q = '{3'd2, 3'd3, 3'd4, 3'd6};
        apply_reset();
        for (int v = 1; v <= 4; v++) begin
            sw = 3'(v);
            tick(8);
        end
        sw = 3'd6;
        tick(6);                    // commit edge is the next one
        checks++;
        if (cmd_data !== 3'd1 || sw_stable !== 3'd4) begin
            errors++;
            $display("FAIL fpp_pre: got head=%0d stable=%0d, want 1/4", cmd_data, sw_stable);
        end
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0 || sw_stable !== 3'd6 || cmd_data !== 3'd2) begin
            errors++;
            $display("FAIL fpp_edge: got ovf=%b stable=%0d head=%0d, want 0/6/2",
                     overflow, sw_stable, cmd_data);
        end
        tick(2);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== exp_q[i]) begin
                errors++;
                $display("FAIL fpp_drain%0d: got valid=%b data=%0d, want 1/%0d",
                         i, cmd_valid, cmd_data, exp_q[i]);
            end
            tick(1);
        end
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_after: got valid=%b ovf=%b, want 0/0", cmd_valid, overflow);
        end
    endtask

    task automatic test_reset_mid_debounce();
        // leave a command queued so the reset has something to discard
        sw = 3'd2;
        tick(8);
        sw = 3'b111;
        tick(2);
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, cmd_data, sw_stable, overflow} !== 8'd0) begin
            errors++;
            $display("FAIL mid_rst_clear: got valid=%b data=%0d stable=%0d ovf=%b, want all 0",
                     cmd_valid, cmd_data, sw_stable, overflow);
        end
        tick(2);
        rst = 1'b1;
        tick(6);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_early: got valid=%b at E0+5, want 0", cmd_valid);
        end
        tick(1);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== 3'd7 || sw_stable !== 3'd7) begin
            errors++;
            $display("FAIL mid_rst_cmd: got valid=%b data=%0d stable=%0d, want 1/7/7",
                     cmd_valid, cmd_data, sw_stable);
        end
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_single: got valid=%b after one pop, want 0", cmd_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_glitch();
        test_handshake();
        test_fill_overflow();
        test_full_push_pop();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
